// File: rtl/wb_arbiter_rr_wdt.sv
// wb_arbiter_rr_wdt
//   Registered N-master to 1-slave Wishbone B4 (classic and burst) arbiter.
//   A winner is picked in IDLE and registered, so the slave sees the granted
//   cycle one clock after the request. The grant is held until the granted
//   master drops cyc, so bursts and RMW sequences are never preempted.
//   Arbitration is round-robin (mode 0) or fixed priority, lowest index first
//   (mode 1).
//
//   Optional watchdog, compiled in with `define WB_ARB_WDT_EN:
//   - A stalled slave cycle is ended with an error to the granted master and
//     a wdt_o pulse.
//   - The arbiter then parks in DRAIN until that master releases cyc.
//
// Handshake:
//   - A master owns the bus once grant_o shows its bit.
//   - A transfer completes in any cycle where the slave sees cyc&stb and
//     returns ack, err or rty.
//   - The response is routed combinationally to the granted master only.
//   - The master must hold its fields stable until that response arrives.
//
// Ports
//   wb_clk_i, wb_rst_i          clock; synchronous active-high reset
//   wbm_*_i                     per-master request fields, master k in slice k
//   wbm_dat_o                   slave read data replicated to every master
//   wbm_ack_o/err_o/rty_o       response, routed to the granted master only
//   wbs_*_o                     granted master's fields; cyc/stb only in BUSY
//   wbs_dat_i/ack_i/err_i/rty_i slave response
//   grant_o                     registered one-hot grant, 0 when idle
//   wdt_o                       one-cycle pulse when the watchdog fires
//   arb_state                   FSM state for debug (0 IDLE, 1 BUSY, 2 DRAIN)
module wb_arbiter_rr_wdt #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 2,
  parameter int mode        = 0,
  parameter int timeout     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [num_masters-1:0]      grant_o,
  output logic                        wdt_o,
  output logic [1:0]                  arb_state
);

  localparam int sw = dw / 8;
  localparam int nm = num_masters;
  localparam int pw = (nm > 1) ? $clog2(nm) : 1;

`ifdef WB_ARB_WDT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_e;
`endif

  state_e        state;
  logic [pw-1:0] gidx;       // index of the last granted master, drives the mux
  logic [pw-1:0] rr_ptr;     // first index the round-robin search looks at
  logic          sel_valid;  // a grant has happened since reset
  logic          busy;
  logic          g_cyc;
  logic          g_stb;
  logic          wdt_fire;

  logic [pw-1:0] win_idx;
  logic          win_found;
  logic [nm-1:0] win_onehot;
  logic [pw-1:0] ptr_next;
  logic [pw:0]   cand;

  // Winner selection. Round-robin rotates the search start, wrapping at nm.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    if (mode == 1) begin
      // Descending scan: the lowest asserted index is written last and wins.
      for (int i = nm - 1; i >= 0; i--) begin
        if (wbm_cyc_i[i]) begin
          win_idx   = pw'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < nm; i++) begin
        cand = {1'b0, rr_ptr} + (pw+1)'(i);
        if (cand >= (pw+1)'(nm)) cand = cand - (pw+1)'(nm);
        if (!win_found && wbm_cyc_i[cand[pw-1:0]]) begin
          win_idx   = cand[pw-1:0];
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int k = 0; k < nm; k++) begin
      win_onehot[k] = win_found && (win_idx == pw'(k));
    end
  end

  assign ptr_next = (win_idx == pw'(nm - 1)) ? '0 : win_idx + 1'b1;

  // Slave-side mux. It keeps showing the last granted master between
  // grants, and reads 0 until the first grant after reset.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    g_cyc     = 1'b0;
    g_stb     = 1'b0;
    for (int k = 0; k < nm; k++) begin
      if (sel_valid && gidx == pw'(k)) begin
        wbs_adr_o = wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbm_sel_i[k*sw +: sw];
        wbs_we_o  = wbm_we_i[k];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
        g_cyc     = wbm_cyc_i[k];
        g_stb     = wbm_stb_i[k];
      end
    end
  end

  assign busy      = (state == BUSY);
  assign wbs_cyc_o = busy & g_cyc;
  assign wbs_stb_o = busy & g_cyc & g_stb;
  assign wbm_dat_o = sel_valid ? {nm{wbs_dat_i}} : '0;
  assign wbm_ack_o = {nm{wbs_cyc_o & wbs_ack_i}} & grant_o;
  assign wbm_err_o = {nm{wbs_cyc_o & (wbs_err_i | wdt_fire)}} & grant_o;
  assign wbm_rty_o = {nm{wbs_cyc_o & wbs_rty_i}} & grant_o;
  assign wdt_o     = wdt_fire;
  assign arb_state = state;

`ifdef WB_ARB_WDT_EN
  logic        resp;
  logic [15:0] wdt_cnt;  // stalled strobe cycles in the current beat
  assign resp     = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wdt_fire = wbs_stb_o && !resp && (wdt_cnt == 16'(timeout));
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(timeout);
  assign wdt_fire       = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      sel_valid <= 1'b0;
`ifdef WB_ARB_WDT_EN
      wdt_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= BUSY;
            grant_o   <= win_onehot;
            gidx      <= win_idx;
            sel_valid <= 1'b1;
            if (mode == 0) rr_ptr <= ptr_next;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state   <= IDLE;
            grant_o <= '0;
          end
`ifdef WB_ARB_WDT_EN
          else if (wdt_fire) begin
            state <= DRAIN;
          end
`endif
        end
`ifdef WB_ARB_WDT_EN
        // Slave responses are ignored here; only the master's release matters.
        DRAIN: begin
          if (!g_cyc) begin
            state   <= IDLE;
            grant_o <= '0;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
`ifdef WB_ARB_WDT_EN
      // Only counts while a strobe waits; any response, idle or drain clears.
      if (wbs_stb_o && !resp && !wdt_fire) wdt_cnt <= wdt_cnt + 16'd1;
      else wdt_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr_wdt.sv
// Bench for wb_arbiter_rr_wdt. Instance 0 is round-robin, instance 1 is
// fixed priority; both are 3 masters, 16-bit address and data.
module tb_wb_arbiter_rr_wdt;
  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam int W   = N + AW;
  localparam logic [DW-1:0] SLV_DATA = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_adr [2];
  logic [N*DW-1:0] m_dat [2];
  logic [N*SW-1:0] m_sel [2];
  logic [N-1:0]    m_we [2], m_cyc [2], m_stb [2];
  logic [N*3-1:0]  m_cti [2];
  logic [N*2-1:0]  m_bte [2];
  logic [N*DW-1:0] r_dat [2];
  logic [N-1:0]    r_ack [2], r_err [2], r_rty [2];
  logic [AW-1:0]   s_adr [2];
  logic [DW-1:0]   s_dato [2];
  logic [SW-1:0]   s_sel [2];
  logic            s_we [2], s_cyc [2], s_stb [2];
  logic [2:0]      s_cti [2];
  logic [1:0]      s_bte [2];
  logic [DW-1:0]   s_dati [2];
  logic            s_ack [2], s_err [2], s_rty [2];
  logic [N-1:0]    grant [2];
  logic            wdt [2];
  logic [1:0]      st [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    wb_arbiter_rr_wdt #(.dw(DW), .aw(AW), .num_masters(N), .mode(d), .timeout(TMO)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_i(m_adr[d]), .wbm_dat_i(m_dat[d]), .wbm_sel_i(m_sel[d]),
      .wbm_we_i(m_we[d]), .wbm_cyc_i(m_cyc[d]), .wbm_stb_i(m_stb[d]),
      .wbm_cti_i(m_cti[d]), .wbm_bte_i(m_bte[d]),
      .wbm_dat_o(r_dat[d]), .wbm_ack_o(r_ack[d]), .wbm_err_o(r_err[d]), .wbm_rty_o(r_rty[d]),
      .wbs_adr_o(s_adr[d]), .wbs_dat_o(s_dato[d]), .wbs_sel_o(s_sel[d]), .wbs_we_o(s_we[d]),
      .wbs_cyc_o(s_cyc[d]), .wbs_stb_o(s_stb[d]), .wbs_cti_o(s_cti[d]), .wbs_bte_o(s_bte[d]),
      .wbs_dat_i(s_dati[d]), .wbs_ack_i(s_ack[d]), .wbs_err_i(s_err[d]), .wbs_rty_i(s_rty[d]),
      .grant_o(grant[d]), .wdt_o(wdt[d]), .arb_state(st[d])
    );
  end

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [N-1:0] prev_g [2];
  logic [N-1:0] held [2];
  logic         mon_en = 1'b0;

  // Slave model state
  int slv_wait [2];
  logic slv_en [2];
  int wcnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [N-1:0] g, input logic [AW-1:0] a);
    if (d == 0) exp_q0.push_back({g, a});
    else exp_q1.push_back({g, a});
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_grant", 32'(grant[d]), 32'd0);
      check("rst_cyc_stb", 32'({s_cyc[d], s_stb[d]}), 32'd0);
      check("rst_s_adr", 32'(s_adr[d]), 32'd0);
      check("rst_m_rsp", 32'({r_ack[d], r_err[d], r_rty[d]}), 32'd0);
      check("rst_m_dat", 32'(r_dat[d][0 +: DW]), 32'd0);
      check("rst_wdt_state", 32'({wdt[d], st[d]}), 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // One master transaction of 'beats' beats (incrementing burst if > 1).
  task automatic master_cycle(input int d, input int m, input int beats, input logic [AW-1:0] a);
    int got;
    int n;
    logic [AW-1:0] cur;
    logic [2:0] cti;
    got = 0;
    n = 0;
    cur = a;
    cti = (beats > 1) ? 3'b010 : 3'b000;
    @(posedge clk); #1;
    m_adr[d][m*AW +: AW] = cur;
    m_cti[d][m*3 +: 3] = cti;
    m_we[d][m] = 1'b1;
    m_cyc[d][m] = 1'b1;
    m_stb[d][m] = 1'b1;
    while (got < beats && n < 200) begin
      @(negedge clk);
      n++;
      if (r_ack[d][m]) begin
        check("beat_adr", 32'(s_adr[d]), 32'(cur));
        check("beat_cti", 32'(s_cti[d]), 32'(cti));
        got++;
        @(posedge clk); #1;
        if (got < beats) begin
          cur = a + AW'(got);
          cti = (got == beats - 1) ? 3'b111 : 3'b010;
          m_adr[d][m*AW +: AW] = cur;
          m_cti[d][m*3 +: 3] = cti;
        end
      end
    end
    if (got < beats) begin
      n_checks++;
      n_errors++;
      $display("FAIL cycle_timeout: dut%0d m%0d got %0d of %0d acks", d, m, got, beats);
      @(posedge clk); #1;
    end
    m_cyc[d][m] = 1'b0;
    m_stb[d][m] = 1'b0;
    m_cti[d][m*3 +: 3] = 3'b000;
  endtask

  // Slave responder: acks after slv_wait[d] stalled strobe cycles.
  initial begin
    forever begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
        if (s_cyc[d] && s_stb[d] && slv_en[d]) begin
          if (wcnt[d] >= slv_wait[d]) begin
            s_ack[d] = 1'b1;
            wcnt[d] = 0;
          end else begin
            s_ack[d] = 1'b0;
            wcnt[d]++;
          end
        end else begin
          s_ack[d] = 1'b0;
          wcnt[d] = 0;
        end
      end
    end
  end

  // Monitor: every new grant pops the expected {grant, address}.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (grant[d] != '0 && prev_g[d] == '0) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_grant: dut%0d grant %b, none expected", d, grant[d]);
            end else begin
              if (d == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              check("grant_order", 32'({grant[d], s_adr[d]}), 32'(e));
              held[d] = e[W-1:AW];
            end
          end else if (grant[d] != '0) begin
            check("grant_hold", 32'(grant[d]), 32'(held[d]));
          end
`ifndef WB_ARB_WDT_EN
          if (wdt[d]) check("wdt_tied", 32'(wdt[d]), 32'd0);
`endif
          prev_g[d] = grant[d];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '1;
      m_dat[d] = {N{16'h1234}};
      m_sel[d] = '1;
      m_we[d] = '0;
      m_cyc[d] = '0;
      m_stb[d] = '0;
      m_cti[d] = '0;
      m_bte[d] = '0;
      s_dati[d] = SLV_DATA;
      s_ack[d] = 1'b0;
      s_err[d] = 1'b0;
      s_rty[d] = 1'b0;
      slv_wait[d] = 0;
      slv_en[d] = 1'b1;
      wcnt[d] = 0;
      prev_g[d] = '0;
      held[d] = '0;
    end

    // Single cycle on m0: grant at cycle 1, slave ack at cycle 3
    do_reset();
    mon_en = 1'b1;
    slv_wait[0] = 2;
    push_exp(0, 3'b001, 16'h0010);
    @(posedge clk); #1;
    m_adr[0][0 +: AW] = 16'h0010;
    m_cyc[0][0] = 1'b1;
    m_stb[0][0] = 1'b1;
    @(negedge clk);
    check("t1_c0_grant", 32'(grant[0]), 32'd0);
    check("t1_c0_cyc", 32'(s_cyc[0]), 32'd0);
    @(negedge clk);
    check("t1_c1_grant", 32'(grant[0]), 32'b001);
    check("t1_c1_cyc_stb", 32'({s_cyc[0], s_stb[0]}), 32'b11);
    check("t1_c1_state", 32'(st[0]), 32'd1);
    @(negedge clk);
    check("t1_c2_ack", 32'(r_ack[0]), 32'd0);
    @(negedge clk);
    check("t1_c3_ack", 32'(r_ack[0]), 32'b001);
    check("t1_c3_dat_m0", 32'(r_dat[0][0 +: DW]), 32'(SLV_DATA));
    check("t1_c3_dat_m2", 32'(r_dat[0][2*DW +: DW]), 32'(SLV_DATA));
    @(posedge clk); #1;
    m_cyc[0][0] = 1'b0;
    m_stb[0][0] = 1'b0;
    @(negedge clk);
    check("t1_c4_cyc", 32'(s_cyc[0]), 32'd0);
    @(negedge clk);
    check("t1_c5_grant", 32'(grant[0]), 32'd0);
    check("t1_c5_state", 32'(st[0]), 32'd0);

    // Round-robin among three masters, m0 comes back a second time
    do_reset();
    slv_wait[0] = 0;
    push_exp(0, 3'b001, 16'h0020);
    push_exp(0, 3'b010, 16'h0030);
    push_exp(0, 3'b100, 16'h0040);
    push_exp(0, 3'b001, 16'h0024);
    fork
      begin
        master_cycle(0, 0, 1, 16'h0020);
        master_cycle(0, 0, 1, 16'h0024);
      end
      master_cycle(0, 1, 1, 16'h0030);
      master_cycle(0, 2, 1, 16'h0040);
    join

    // Fixed priority: m0 and m2 together, m1 joins during m0's cycle
    do_reset();
    slv_wait[1] = 2;
    push_exp(1, 3'b001, 16'h0050);
    push_exp(1, 3'b010, 16'h0060);
    push_exp(1, 3'b100, 16'h0070);
    fork
      master_cycle(1, 0, 1, 16'h0050);
      master_cycle(1, 2, 1, 16'h0070);
      begin
        repeat (2) @(posedge clk);
        master_cycle(1, 1, 1, 16'h0060);
      end
    join

    // m1 burst of four is not preempted by m0
    do_reset();
    slv_wait[0] = 1;
    push_exp(0, 3'b010, 16'h0100);
    push_exp(0, 3'b001, 16'h0080);
    fork
      master_cycle(0, 1, 4, 16'h0100);
      begin
        repeat (2) @(posedge clk);
        master_cycle(0, 0, 1, 16'h0080);
      end
    join

`ifdef WB_ARB_WDT_EN
    // Watchdog: slave never answers
    do_reset();
    slv_en[0] = 1'b0;
    push_exp(0, 3'b001, 16'h0500);
    @(posedge clk); #1;
    m_adr[0][0 +: AW] = 16'h0500;
    m_cyc[0][0] = 1'b1;
    m_stb[0][0] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      check("t5_quiet", 32'({r_err[0], wdt[0]}), 32'd0);
    end
    @(negedge clk);
    check("t5_err", 32'(r_err[0]), 32'b001);
    check("t5_wdt", 32'(wdt[0]), 32'd1);
    @(negedge clk);
    check("t5_cyc_drop", 32'(s_cyc[0]), 32'd0);
    check("t5_no_repeat", 32'({r_err[0], wdt[0]}), 32'd0);
    check("t5_drain", 32'(st[0]), 32'd2);
    @(posedge clk); #1;
    m_cyc[0][0] = 1'b0;
    m_stb[0][0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_idle_grant", 32'(grant[0]), 32'd0);
    check("t5_idle_state", 32'(st[0]), 32'd0);
    slv_en[0] = 1'b1;
`endif

    // Reset during the second beat of an m1 burst
    do_reset();
    slv_wait[0] = 1;
    push_exp(0, 3'b001, 16'h0200);
    master_cycle(0, 0, 1, 16'h0200);
    push_exp(0, 3'b010, 16'h0300);
    @(posedge clk); #1;
    m_adr[0][AW +: AW] = 16'h0300;
    m_cti[0][3 +: 3] = 3'b010;
    m_cyc[0][1] = 1'b1;
    m_stb[0][1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r_ack[0][1] && n < 50);
    check("t6_first_ack", 32'(r_ack[0][1]), 32'd1);
    @(posedge clk); #1;
    m_adr[0][AW +: AW] = 16'h0301;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cyc[0][1] = 1'b0;
    m_stb[0][1] = 1'b0;
    m_cti[0][3 +: 3] = 3'b000;
    @(negedge clk);
    check("t6_grant", 32'(grant[0]), 32'd0);
    check("t6_cyc", 32'(s_cyc[0]), 32'd0);
    check("t6_s_adr", 32'(s_adr[0]), 32'd0);
    check("t6_state", 32'(st[0]), 32'd0);
    push_exp(0, 3'b001, 16'h0210);
    push_exp(0, 3'b100, 16'h0410);
    fork
      master_cycle(0, 0, 1, 16'h0210);
      master_cycle(0, 2, 1, 16'h0410);
    join

    repeat (5) @(posedge clk);
    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
